// File: rtl/soc_periph_apb_bridge.sv
// soc_periph_apb_bridge: TCDM-to-APB4 bridge serving NR_APB_SLAVES targets through a runtime rule table,
// one transfer at a time, with slave timeout and TCDM error responses.
module soc_periph_apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NR_APB_SLAVES = 4,
    parameter int NR_ADDR_RULES = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 'hBADACCE5
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                req_i,
    input  logic [ADDR_WIDTH-1:0]                               add_i,
    input  logic                                                wen_i,
    input  logic [DATA_WIDTH-1:0]                               wdata_i,
    input  logic [DATA_WIDTH/8-1:0]                             be_i,
    output logic                                                gnt_o,
    output logic                                                r_valid_o,
    output logic [DATA_WIDTH-1:0]                               r_rdata_o,
    output logic                                                r_opc_o,
    input  logic [NR_ADDR_RULES-1:0][2*ADDR_WIDTH+31:0]         addr_map_i,
    output logic [ADDR_WIDTH-1:0]                               paddr_o,
    output logic [DATA_WIDTH-1:0]                               pwdata_o,
    output logic                                                pwrite_o,
    output logic [DATA_WIDTH/8-1:0]                             pstrb_o,
    output logic [2:0]                                          pprot_o,
    output logic [NR_APB_SLAVES-1:0]                            psel_o,
    output logic                                                penable_o,
    input  logic [NR_APB_SLAVES-1:0]                            pready_i,
    input  logic [NR_APB_SLAVES-1:0][DATA_WIDTH-1:0]            prdata_i,
    input  logic [NR_APB_SLAVES-1:0]                            pslverr_i
);
    localparam int SW = NR_APB_SLAVES > 1 ? $clog2(NR_APB_SLAVES) : 1;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef struct packed {
        logic [31:0]           idx;
        logic [ADDR_WIDTH-1:0] start_addr;
        logic [ADDR_WIDTH-1:0] end_addr;
    } addr_map_rule_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t         state;
    addr_map_rule_t rule;
    logic [SW-1:0]  sel;
    logic [SW-1:0]  dec_idx;
    logic           dec_hit;
    logic           wen_q;
    logic [CW-1:0]  cnt;
    logic           timeout;
    logic           done;

    assign gnt_o = req_i && (state == IDLE || state == RESP);
    assign pprot_o = 3'b000;
    assign timeout = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES);
    assign done = pready_i[sel] || timeout;

    // Later rules override earlier ones; an out-of-range slave index turns the match into a miss.
    always_comb begin
        rule = '0;
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = 0; i < NR_ADDR_RULES; i++) begin
            rule = addr_map_i[i];
            if (add_i >= rule.start_addr && add_i < rule.end_addr) begin
                dec_hit = rule.idx < 32'(NR_APB_SLAVES);
                dec_idx = SW'(rule.idx);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            sel <= '0;
            wen_q <= 1'b0;
            cnt <= '0;
            paddr_o <= '0;
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
            pstrb_o <= '0;
            psel_o <= '0;
            penable_o <= 1'b0;
            r_valid_o <= 1'b0;
            r_rdata_o <= '0;
            r_opc_o <= 1'b0;
        end else begin
            r_valid_o <= 1'b0;
            if (gnt_o) begin
                cnt <= '0;
                if (dec_hit) begin
                    state <= SETUP;
                    sel <= dec_idx;
                    wen_q <= wen_i;
                    paddr_o <= add_i;
                    pwdata_o <= wdata_i;
                    pwrite_o <= ~wen_i;
                    pstrb_o <= wen_i ? '0 : be_i;
                    psel_o <= NR_APB_SLAVES'(1) << dec_idx;
                end else begin
                    state <= RESP;
                    r_valid_o <= 1'b1;
                    r_rdata_o <= wen_i ? ERR_RDATA : '0;
                    r_opc_o <= 1'b1;
                end
            end else begin
                case (state)
                    SETUP: begin
                        state <= ACCESS;
                        penable_o <= 1'b1;
                    end
                    ACCESS: begin
                        if (done) begin
                            state <= RESP;
                            psel_o <= '0;
                            penable_o <= 1'b0;
                            pstrb_o <= '0;
                            r_valid_o <= 1'b1;
                            r_opc_o <= !pready_i[sel] || pslverr_i[sel];
                            r_rdata_o <= !wen_q ? '0 : pready_i[sel] ? prdata_i[sel] : ERR_RDATA;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_soc_periph_apb_bridge.sv
// tb_soc_periph_apb_bridge: directed scoreboard bench for the TCDM-to-APB bridge.
module tb_soc_periph_apb_bridge;
    localparam int NS = 4;
    localparam int NR = 4;
    localparam logic [31:0] ERR = 32'hBADACCE5;

    typedef struct packed {
        logic [31:0] rdata;
        logic        opc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic [31:0] add = '0;
    logic wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] be = '0;
    logic gnt, r_valid, r_opc, pwrite, penable;
    logic [31:0] r_rdata, paddr, pwdata;
    logic [NR-1:0][95:0] addr_map;
    logic [3:0] pstrb;
    logic [2:0] pprot;
    logic [NS-1:0] psel, pready, pslverr;
    logic [NS-1:0][31:0] prdata;

    int slv_wait = 0;
    logic slv_hang = 1'b0;
    logic slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;
    int wcnt = 0;
    int checks = 0;
    int passed = 0;
    int failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    soc_periph_apb_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc), .addr_map_i(addr_map),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .pstrb_o(pstrb), .pprot_o(pprot),
        .psel_o(psel), .penable_o(penable), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    // Slaves that are not selected look ready, erroring and return inverted data to expose mis-steering.
    always @(posedge clk) wcnt <= penable ? wcnt + 1 : 0;
    for (genvar g = 0; g < NS; g++) begin : g_slv
        assign pready[g] = psel[g] ? (!slv_hang && wcnt >= slv_wait) : 1'b1;
        assign prdata[g] = psel[g] ? slv_rdata : ~slv_rdata;
        assign pslverr[g] = psel[g] ? slv_err : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (r_valid) begin
            if (sb.size() == 0) chk("spurious_rvalid", 32'(r_valid), 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", r_rdata, e.rdata);
                chk("opc", 32'(r_opc), 32'(e.opc));
            end
        end
    end

    // Called at posedge+1 with the bridge in IDLE or RESP; returns at posedge+1 of the response cycle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] b,
                        input logic [3:0] ps, input int lat, input logic [31:0] er, input logic eo);
        int n;
        req = 1'b1; add = a; wen = w; wdata = d; be = b;
        sb.push_back({er, eo});
        #1 chk("gnt", 32'(gnt), 1);
        @(posedge clk); #1;
        req = 1'b0;
        n = 1;
        chk("psel_setup", 32'(psel), 32'(ps));
        if (ps != 0) begin
            chk("penable_setup", 32'(penable), 0);
            chk("pwrite", 32'(pwrite), 32'(!w));
            chk("pstrb", 32'(pstrb), w ? 0 : 32'(b));
            chk("paddr", paddr, a);
            chk("pwdata", pwdata, d);
        end
        while (!r_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 2 && ps != 0) begin
                chk("penable_access", 32'(penable), 1);
                chk("psel_access", 32'(psel), 32'(ps));
            end
        end
        chk("latency", 32'(n), 32'(lat));
        chk("apb_idle_resp", {27'd0, psel, penable}, 0);
    endtask

    initial begin
        addr_map[0] = {32'd2, 32'h1A10_0000, 32'h1A10_1000};
        addr_map[1] = {32'd5, 32'h2000_0000, 32'h2000_1000};
        addr_map[2] = {32'd1, 32'h3000_0000, 32'h3000_2000};
        addr_map[3] = {32'd3, 32'h3000_1000, 32'h3000_1800};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rvalid", 32'(r_valid), 0);
        chk("rst_rdata", r_rdata, 0);
        chk("rst_pprot", 32'(pprot), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        slv_rdata = 32'h1234_5678;
        xfer(32'h1A10_0040, 1'b1, 32'h0, 4'hF, 4'b0100, 3, 32'h1234_5678, 1'b0);
        slv_wait = 3;
        xfer(32'h1A10_0080, 1'b0, 32'hCAFE_F00D, 4'b0110, 4'b0100, 6, 32'h0, 1'b0);
        slv_wait = 0;
        xfer(32'h0000_0000, 1'b1, 32'h0, 4'hF, 4'b0000, 1, ERR, 1'b1);
        xfer(32'h2000_0010, 1'b1, 32'h0, 4'hF, 4'b0000, 1, ERR, 1'b1);
        xfer(32'h1A10_1000, 1'b1, 32'h0, 4'hF, 4'b0000, 1, ERR, 1'b1);
        xfer(32'h1A10_1000, 1'b0, 32'h5, 4'hF, 4'b0000, 1, 32'h0, 1'b1);
        slv_hang = 1'b1;
        xfer(32'h1A10_0000, 1'b1, 32'h0, 4'hF, 4'b0100, 7, ERR, 1'b1);
        slv_hang = 1'b0;
        slv_wait = 1;
        slv_rdata = 32'hA5A5_0001;
        xfer(32'h1A10_0FFC, 1'b1, 32'h0, 4'hF, 4'b0100, 4, 32'hA5A5_0001, 1'b0);
        slv_wait = 0;
        slv_err = 1'b1;
        xfer(32'h3000_1800, 1'b0, 32'h7777_8888, 4'b1001, 4'b0010, 3, 32'h0, 1'b1);
        slv_err = 1'b0;
        @(posedge clk); #1;
        // back-to-back with req held high; overlapping rule 3 beats rule 2
        slv_rdata = 32'h1111_2222;
        req = 1'b1; add = 32'h3000_1004; wen = 1'b1; be = 4'hF;
        sb.push_back({32'h1111_2222, 1'b0});
        #1 chk("b2b_gnt1", 32'(gnt), 1);
        @(posedge clk); #1;
        chk("b2b_psel1", 32'(psel), 32'(4'b1000));
        chk("b2b_gnt_busy", 32'(gnt), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_rvalid1", 32'(r_valid), 1);
        chk("b2b_gnt_resp", 32'(gnt), 1);
        add = 32'h3000_0010;
        slv_rdata = 32'h3333_4444;
        slv_err = 1'b1;
        sb.push_back({32'h3333_4444, 1'b1});
        @(posedge clk); #1;
        req = 1'b0;
        chk("b2b_psel2", 32'(psel), 32'(4'b0010));
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_rvalid2", 32'(r_valid), 1);
        slv_err = 1'b0;
        @(posedge clk); #1;
        chk("b2b_rvalid_drop", 32'(r_valid), 0);
        // reset in the middle of ACCESS drops the transfer
        slv_hang = 1'b1;
        req = 1'b1; add = 32'h1A10_0100; wen = 1'b0; wdata = 32'hDEAD_BEEF; be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("mid_penable", 32'(penable), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_psel", 32'(psel), 0);
        chk("mid_rst_penable", 32'(penable), 0);
        chk("mid_rst_paddr", paddr, 0);
        chk("mid_rst_pwdata", pwdata, 0);
        chk("mid_rst_pwrite", 32'(pwrite), 0);
        chk("mid_rst_pstrb", 32'(pstrb), 0);
        chk("mid_rst_rvalid", 32'(r_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        slv_hang = 1'b0;
        slv_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        xfer(32'h1A10_0200, 1'b1, 32'h0, 4'hF, 4'b0100, 3, 32'h0BAD_F00D, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/soc_periph_apb_bridge.md
# soc_periph_apb_bridge

Multi-slave TCDM-to-APB bridge for the SoC peripheral region, replacing the single-port APB path behind the interconnect with a parametrised bridge that serves `NR_APB_SLAVES` APB4 targets. It accepts one TCDM-style request at a time and decodes it against a runtime rule table. It runs a per-transfer APB SETUP/ACCESS sequence, forwards byte strobes, and aborts hung slaves with a timeout. Decode misses, `pslverr` and timeouts are reported as TCDM error responses.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; must be a multiple of 8.
- `NR_APB_SLAVES`, 4, number of APB targets (≥1).
- `NR_ADDR_RULES`, 4, number of address rules (≥1).
- `TIMEOUT_CYCLES`, 256, maximum ACCESS wait cycles; 0 disables the timeout.
- `ERR_RDATA`, 32'hBADACCE5, read data returned on decode miss or timeout.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  1  TCDM request.
- `add_i`  in  ADDR_WIDTH  byte address.
- `wen_i`  in  1  1 = read, 0 = write.
- `wdata_i`  in  DATA_WIDTH  write data.
- `be_i`  in  DATA_WIDTH/8  byte enables.
- `gnt_o`  out  1  request accepted.
- `r_valid_o`  out  1  response valid, one cycle.
- `r_rdata_o`  out  DATA_WIDTH  response data.
- `r_opc_o`  out  1  1 = error response.
- `addr_map_i`  in  NR_ADDR_RULES × addr_map_rule_t  rules {idx, start_addr, end_addr}.
- `paddr_o`  out  ADDR_WIDTH  APB address.
- `pwdata_o`  out  DATA_WIDTH  APB write data.
- `pwrite_o`  out  1  APB direction.
- `pstrb_o`  out  DATA_WIDTH/8  APB strobes.
- `pprot_o`  out  3  constant 3'b000.
- `psel_o`  out  NR_APB_SLAVES  one-hot select.
- `penable_o`  out  1  APB enable.
- `pready_i`  in  NR_APB_SLAVES  per-slave ready.
- `prdata_i`  in  NR_APB_SLAVES × DATA_WIDTH  per-slave read data.
- `pslverr_i`  in  NR_APB_SLAVES  per-slave error.

## Operation
- **States.** IDLE, SETUP, ACCESS, RESP.
- **Grant.** `gnt_o = req_i` when the state is IDLE or RESP; otherwise `gnt_o` is 0.
- **Acceptance** (`req_i && gnt_o`):
  - Register `add_i`, `wdata_i`, `be_i` and `wen_i`.
  - Decode the address. A rule matches when `start_addr <= add_i < end_addr` (end exclusive).
  - If several rules match, the highest rule index wins.
  - A match whose `idx >= NR_APB_SLAVES` counts as a miss.
- **On hit:** go to SETUP with the decoded index registered.
- **On miss:** go to RESP with error; no APB activity.
- **SETUP:**
  - `psel_o[idx]=1`, `penable_o=0`.
  - `paddr_o`, `pwdata_o` = registered values.
  - `pwrite_o = ~wen`.
  - `pstrb_o = wen ? 0 : be` (APB4: zero strobes on reads).
  - Always moves to ACCESS next cycle.
- **ACCESS:**
  - `psel_o[idx]=1`, `penable_o=1`.
  - Only `pready_i[idx]`, `prdata_i[idx]` and `pslverr_i[idx]` are observed.
  - On `pready_i[idx]`: capture the data and error, go to RESP.
  - Otherwise increment the timeout counter, width `$clog2(TIMEOUT_CYCLES+1)`, cleared on entering SETUP.
  - When the counter equals `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES != 0`): deassert `psel_o`/`penable_o` and go to RESP with error.
- **RESP:**
  - `r_valid_o=1` for exactly one cycle.
  - Read, no error: `r_rdata_o = prdata`, `r_opc_o=0`.
  - Read with pslverr: `r_rdata_o = prdata`, `r_opc_o=1`.
  - Read with decode miss or timeout: `r_rdata_o = ERR_RDATA`, `r_opc_o=1`.
  - Writes: `r_rdata_o = 0`; `r_opc_o` as above.
  - A new request accepted in RESP goes straight to SETUP (hit) or RESP (miss); otherwise go to IDLE.
- **APB outputs between transfers:** `psel_o`, `penable_o`, `pstrb_o` are 0 in IDLE and RESP; `paddr_o`, `pwdata_o` and `pwrite_o` hold their last values.
- **Reset:**
  - Asserting `rst_i` forces IDLE immediately and clears the counter.
  - All outputs go to 0 (`paddr_o`, `pwdata_o`, `r_rdata_o` = 0).
  - A transfer in flight is dropped: no response is issued and `psel_o` deasserts asynchronously.

## Timing
- **Hit with zero-wait slave:** accept at T; SETUP T+1; ACCESS T+2 with `pready` high; `r_valid_o` at T+3.
- **Wait states:** each cycle `pready` stays low adds one cycle.
- **Decode miss:** `r_valid_o` at T+1.
- **Back-to-back throughput:** one transfer per 3 cycles (accept in RESP).
- **Timeout:** ACCESS lasts `TIMEOUT_CYCLES+1` cycles; the error response comes the cycle after.
- **Registered vs combinational:** all APB outputs and response outputs are registered; only `gnt_o` is combinational from `req_i` and the state.
- **Rule table:** `addr_map_i` is sampled only in the acceptance cycle.
- **Unselected slaves:** `pready_i` from unselected slaves never affects the state.

## Test plan
- **Read hit.** Rule {idx:2, 0x1A10_0000–0x1A10_1000}; read 0x1A10_0040; slave 2 has `pready` high immediately with `prdata` 0x12345678 -> `psel_o`=4'b0100 at T+1, `penable_o` at T+2, `r_valid_o` at T+3 with rdata 0x12345678 and `r_opc_o=0`.
- **Write with strobes and wait states.** Write 0xCAFEF00D, be 4'b0110; slave holds `pready` low for 3 cycles -> `pstrb_o`=4'b0110, `pwrite_o`=1; response at T+6 with `r_opc_o=0` and rdata 0.
- **Decode miss.** Read 0x0000_0000 with no matching rule, then a second read whose rule idx is 5 with `NR_APB_SLAVES=4` -> no `psel_o`; `r_valid_o` at T+1 with 0xBADACCE5 and `r_opc_o=1`, for both requests.
- **Timeout.** `TIMEOUT_CYCLES=4`; slave never ready -> ACCESS lasts 5 cycles, `psel_o` drops, error response; the next request completes normally.
- **Back-to-back, overlap and pslverr.** Two overlapping rules and back-to-back requests with `req_i` held high -> the higher-index rule's slave is selected; second grant lands in the RESP cycle, giving 3-cycle spacing; `pslverr` on the second returns `r_opc_o=1` with prdata.
- **Reset mid-transfer.** Assert `rst_i` mid-ACCESS -> all outputs 0 immediately; no `r_valid_o`; the first request after reset completes normally.
